// File: rtl/pci_cfg_space_if.sv
// Config-register handshake between the PCI bus interface FSM (master)
// and the type-0 header register file (slave).
interface pci_cfg_space_if;
  logic        cfg_enable;
  logic        cfg_iswrite;
  logic [5:0]  cfg_offset;
  logic [31:0] cfg_write_val;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_read_val;
  logic        cfg_done;
  logic        cfg_w_err;

  modport master (
    output cfg_enable, cfg_iswrite, cfg_offset, cfg_write_val, cfg_be,
    input  cfg_read_val, cfg_done, cfg_w_err
  );

  modport slave (
    input  cfg_enable, cfg_iswrite, cfg_offset, cfg_write_val, cfg_be,
    output cfg_read_val, cfg_done, cfg_w_err
  );
endinterface

// File: rtl/pci_cfg_space.sv
// Type-0 PCI configuration header for the Edu device: IDLE/ACCESS/DONE/RELEASE
// handshake, byte-enabled writes, W1C status events and BAR0 decode.
module pci_cfg_space #(
  parameter logic [15:0] VENDOR_ID        = 16'h1234,
  parameter logic [15:0] DEVICE_ID        = 16'h11E8,
  parameter logic [7:0]  REVISION_ID      = 8'h10,
  parameter logic [23:0] CLASS_CODE       = 24'hFF0000,
  parameter logic [15:0] SUBSYS_VENDOR_ID = 16'h1AF4,
  parameter logic [15:0] SUBSYS_ID        = 16'h1100,
  parameter int          BAR0_SIZE_LOG2   = 20,
  parameter logic [7:0]  INT_PIN          = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  pci_cfg_space_if.slave   cfg,
  input  logic             parity_error_detected,
  input  logic             serr_signaled,
  input  logic             int_status,
  output logic             parity_error_response_reg,
  output logic             serr_enable_reg,
  output logic             mem_space_en,
  output logic             bus_master_en,
  output logic             intx_disable,
  output logic [31:0]      bar0_base
);

  localparam logic [31:0] BAR_MASK = 32'hFFFF_FFFF << BAR0_SIZE_LOG2;
  localparam logic [15:0] CMD_MASK = 16'h0546;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

  typedef struct packed {
    logic        iswrite;
    logic [5:0]  off;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cfg_req_t;

  state_t      state_q;
  cfg_req_t    req_q;
  logic        done_q, w_err_q;
  logic [31:0] rd_val_q;

  logic [15:0] cmd_q, cmd_d;
  logic        pe_q, pe_d, se_q, se_d;
  logic [7:0]  cls_q, cls_d, il_q, il_d;
  logic [31:0] bar_q, bar_d;

  logic [31:0] rd_word, wmask, bemask, m;
  logic [15:0] status;
  logic        wr_en, w_err_c;

  assign status = {pe_q, se_q, 3'b000, 2'b01, 5'b00000, int_status, 3'b000};
  assign bemask = {{8{~req_q.be[3]}}, {8{~req_q.be[2]}}, {8{~req_q.be[1]}}, {8{~req_q.be[0]}}};

  always_comb begin
    rd_word = 32'h0;
    wmask   = 32'h0;
    case (req_q.off)
      6'h00: rd_word = {DEVICE_ID, VENDOR_ID};
      6'h01: begin rd_word = {status, cmd_q}; wmask = {16'hC000, CMD_MASK}; end
      6'h02: rd_word = {CLASS_CODE, REVISION_ID};
      6'h03: begin rd_word = {24'h0, cls_q}; wmask = 32'h0000_00FF; end
      6'h04: begin rd_word = bar_q; wmask = BAR_MASK; end
      6'h0B: rd_word = {SUBSYS_ID, SUBSYS_VENDOR_ID};
      6'h0F: begin rd_word = {16'h0, INT_PIN, il_q}; wmask = 32'h0000_00FF; end
      default: ;
    endcase
  end

  // Error only when something was enabled yet nothing enabled is writable.
  assign m       = wmask & bemask;
  assign w_err_c = (req_q.be != 4'hF) && (m == 32'h0);
  assign wr_en   = (state_q == ACCESS) && req_q.iswrite;

  always_comb begin
    cmd_d = cmd_q;
    cls_d = cls_q;
    bar_d = bar_q;
    il_d  = il_q;
    if (wr_en) begin
      case (req_q.off)
        6'h01: cmd_d = (cmd_q & ~m[15:0]) | (req_q.wdata[15:0] & m[15:0]);
        6'h03: cls_d = (cls_q & ~m[7:0]) | (req_q.wdata[7:0] & m[7:0]);
        6'h04: bar_d = (bar_q & ~m) | (req_q.wdata & m);
        6'h0F: il_d  = (il_q & ~m[7:0]) | (req_q.wdata[7:0] & m[7:0]);
        default: ;
      endcase
    end
    // A new event wins over a same-cycle W1C.
    pe_d = parity_error_detected |
           (pe_q & ~(wr_en && req_q.off == 6'h01 && m[31] && req_q.wdata[31]));
    se_d = serr_signaled |
           (se_q & ~(wr_en && req_q.off == 6'h01 && m[30] && req_q.wdata[30]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q <= '0;
      pe_q  <= 1'b0;
      se_q  <= 1'b0;
      cls_q <= '0;
      bar_q <= '0;
      il_q  <= '0;
    end else begin
      cmd_q <= cmd_d;
      pe_q  <= pe_d;
      se_q  <= se_d;
      cls_q <= cls_d;
      bar_q <= bar_d;
      il_q  <= il_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      done_q   <= 1'b0;
      w_err_q  <= 1'b0;
      rd_val_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg.cfg_enable) begin
          req_q   <= '{iswrite: cfg.cfg_iswrite, off: cfg.cfg_offset,
                       wdata: cfg.cfg_write_val, be: cfg.cfg_be};
          state_q <= ACCESS;
        end
        ACCESS: begin
          done_q   <= 1'b1;
          w_err_q  <= req_q.iswrite & w_err_c;
          rd_val_q <= req_q.iswrite ? 32'h0 : rd_word;
          state_q  <= DONE;
        end
        DONE:    state_q <= RELEASE;
        RELEASE: if (!cfg.cfg_enable) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_done     = done_q;
  assign cfg.cfg_w_err    = w_err_q;
  assign cfg.cfg_read_val = rd_val_q;

  assign mem_space_en              = cmd_q[1];
  assign bus_master_en             = cmd_q[2];
  assign parity_error_response_reg = cmd_q[6];
  assign serr_enable_reg           = cmd_q[8];
  assign intx_disable              = cmd_q[10];
  assign bar0_base                 = bar_q;

endmodule

// File: tb/tb_pci_cfg_space.sv
// Directed bench for pci_cfg_space: header reads, BAR sizing, command/status,
// W1C priority, write errors, held enable and reset mid-access.
module tb_pci_cfg_space;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pe = 1'b0, se = 1'b0, int_st = 1'b1;
  logic per, serr_en, mem_en, bm_en, intx_dis;
  logic [31:0] bar0;
  int n_chk = 0, n_err = 0;

  pci_cfg_space_if cfg_if ();

  pci_cfg_space dut (
    .clk(clk), .rst(rst), .cfg(cfg_if),
    .parity_error_detected(pe), .serr_signaled(se), .int_status(int_st),
    .parity_error_response_reg(per), .serr_enable_reg(serr_en),
    .mem_space_en(mem_en), .bus_master_en(bm_en), .intx_disable(intx_dis),
    .bar0_base(bar0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One handshake; optionally pulse parity_error_detected so it lands on the
  // same edge that applies the write.
  task automatic access(input logic wr, input logic [5:0] off, input logic [31:0] wd,
                        input logic [3:0] be, input logic pe_in_access,
                        output logic [31:0] rd, output logic we, output int lat);
    @(negedge clk);
    cfg_if.cfg_enable    = 1'b1;
    cfg_if.cfg_iswrite   = wr;
    cfg_if.cfg_offset    = off;
    cfg_if.cfg_write_val = wd;
    cfg_if.cfg_be        = be;
    rd = 32'hDEAD_BEEF; we = 1'bx; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) pe = pe_in_access;
      if (i == 2) pe = 1'b0;
      if (cfg_if.cfg_done) begin
        lat = i; rd = cfg_if.cfg_read_val; we = cfg_if.cfg_w_err;
        break;
      end
    end
    pe = 1'b0;
    cfg_if.cfg_enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_rd(input string tag, input logic [5:0] off, input logic [31:0] exp);
    logic [31:0] rd; logic we; int lat;
    access(1'b0, off, 32'h0, 4'h0, 1'b0, rd, we, lat);
    chk({tag, "_lat"}, lat, 2);
    chk(tag, rd, exp);
  endtask

  task automatic do_wr(input string tag, input logic [5:0] off, input logic [31:0] wd,
                       input logic [3:0] be, input logic pe_in_access, input logic exp_err);
    logic [31:0] rd; logic we; int lat;
    access(1'b1, off, wd, be, pe_in_access, rd, we, lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_werr"}, {31'h0, we}, {31'h0, exp_err});
    chk({tag, "_rdval"}, rd, 32'h0);
  endtask

  task automatic pulse(input logic which_serr);
    @(negedge clk);
    if (which_serr) se = 1'b1; else pe = 1'b1;
    @(negedge clk);
    se = 1'b0; pe = 1'b0;
  endtask

  initial begin
    int cnt;
    cfg_if.cfg_enable = 1'b0; cfg_if.cfg_iswrite = 1'b0; cfg_if.cfg_offset = '0;
    cfg_if.cfg_write_val = '0; cfg_if.cfg_be = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'h0, cfg_if.cfg_done}, 32'h0);
    chk("rst_werr", {31'h0, cfg_if.cfg_w_err}, 32'h0);
    chk("rst_rdval", cfg_if.cfg_read_val, 32'h0);
    chk("rst_bar0", bar0, 32'h0);
    chk("rst_cmd", {27'h0, intx_dis, serr_en, per, bm_en, mem_en}, 32'h0);
    @(negedge clk); rst = 1'b1;

    do_rd("id", 6'h00, 32'h11E8_1234);
    do_rd("class", 6'h02, 32'hFF00_0010);
    do_rd("subsys", 6'h0B, 32'h1100_1AF4);
    do_wr("bar_size_wr", 6'h04, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0);
    do_rd("unmapped10", 6'h10, 32'h0);
    do_rd("unmapped3f", 6'h3F, 32'h0);
    do_rd("bar_size", 6'h04, 32'hFFF0_0000);
    do_wr("bar_wr", 6'h04, 32'hFEB0_0000, 4'b0000, 1'b0, 1'b0);
    chk("bar0_base", bar0, 32'hFEB0_0000);
    do_wr("bar_no_be", 6'h04, 32'h1234_5678, 4'b1111, 1'b0, 1'b0);
    chk("bar0_kept", bar0, 32'hFEB0_0000);

    do_wr("cmd_wr", 6'h01, 32'h0000_0546, 4'b1100, 1'b0, 1'b0);
    chk("cmd_outs", {27'h0, intx_dis, serr_en, per, bm_en, mem_en}, 32'h1F);
    do_rd("cmd_rd", 6'h01, 32'h0208_0546);
    do_wr("stat_ro_byte", 6'h01, 32'hFFFF_FFFF, 4'b1011, 1'b0, 1'b1);
    do_rd("cmd_rd2", 6'h01, 32'h0208_0546);

    pulse(1'b0);
    do_rd("pe_set", 6'h01, 32'h8208_0546);
    do_wr("pe_clr_wr", 6'h01, 32'h8000_0000, 4'b0111, 1'b0, 1'b0);
    do_rd("pe_clr", 6'h01, 32'h0208_0546);
    pulse(1'b0);
    do_wr("pe_race_wr", 6'h01, 32'h8000_0000, 4'b0111, 1'b1, 1'b0);
    do_rd("pe_race", 6'h01, 32'h8208_0546);
    pulse(1'b1);
    do_rd("serr_set", 6'h01, 32'hC208_0546);
    do_wr("serr_clr_wr", 6'h01, 32'h4000_0000, 4'b0111, 1'b0, 1'b0);
    do_rd("serr_clr", 6'h01, 32'h8208_0546);

    do_wr("ro_wr", 6'h00, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1);
    do_rd("ro_kept", 6'h00, 32'h11E8_1234);
    do_wr("il_wr", 6'h0F, 32'hFFFF_FF0B, 4'b1110, 1'b0, 1'b0);
    do_rd("il_rd", 6'h0F, 32'h0000_010B);
    do_wr("cls_wr", 6'h03, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0);
    do_rd("cls_rd", 6'h03, 32'h0000_00FF);

    // Enable held high: exactly one completion.
    @(negedge clk);
    cfg_if.cfg_enable = 1'b1; cfg_if.cfg_iswrite = 1'b0; cfg_if.cfg_offset = 6'h00;
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (cfg_if.cfg_done) cnt++; end
    cfg_if.cfg_enable = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (cfg_if.cfg_done) cnt++; end
    chk("hold_one_done", cnt, 1);

    // Reset while in ACCESS.
    @(negedge clk);
    cfg_if.cfg_enable = 1'b1; cfg_if.cfg_iswrite = 1'b0; cfg_if.cfg_offset = 6'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (cfg_if.cfg_done) cnt++; end
    cfg_if.cfg_enable = 1'b0;
    chk("rst_abort_done", cnt, 0);
    chk("rst2_bar0", bar0, 32'h0);
    chk("rst2_cmd", {27'h0, intx_dis, serr_en, per, bm_en, mem_en}, 32'h0);
    chk("rst2_rdval", cfg_if.cfg_read_val, 32'h0);
    @(negedge clk); rst = 1'b1;
    do_rd("post_rst_stat", 6'h01, 32'h0208_0000);
    do_rd("post_rst_il", 6'h0F, 32'h0000_0100);
    do_rd("post_rst_cls", 6'h03, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
